// File: rtl/ula_seq.sv
// ula_seq: registered WIDTH-bit ALU with valid/ready handshake, 1-bit/cycle shifter and Z/C/S/O flags.
// Define ULA_SAT_EN to clamp ADD/ADDI/SUB/SUBD/INC/DEC results on signed overflow instead of wrapping.
module ula_seq #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_s,
    output logic             flag_o,
    output logic             out_err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CALC  = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_ADDI = 5'b00001;
    localparam logic [4:0] OP_INC  = 5'b00011;
    localparam logic [4:0] OP_SUBD = 5'b00100;
    localparam logic [4:0] OP_SUB  = 5'b00101;
    localparam logic [4:0] OP_DEC  = 5'b00110;
    localparam logic [4:0] OP_LSL  = 5'b01000;
    localparam logic [4:0] OP_LSR  = 5'b01001;
    localparam logic [4:0] OP_ASR  = 5'b01010;
    localparam logic [4:0] OP_AND  = 5'b10000;
    localparam logic [4:0] OP_OR   = 5'b10001;
    localparam logic [4:0] OP_XOR  = 5'b10010;
    localparam logic [4:0] OP_NOT  = 5'b10011;

    localparam logic [SHW-1:0] SH_MAX = SHW'(WIDTH);
    localparam logic [SHW-1:0] SH_ONE = SHW'(1);

    logic [1:0]       state_q, state_d;
    logic [4:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             z_q, z_d, c_q, c_d, s_q, s_d, o_q, o_d;
    logic             err_q, err_d;
    logic [SHW-1:0]   cnt_q, cnt_d;

    logic             isArith, isLogic, isShift;
    logic [WIDTH-1:0] addX, addY;
    logic             addCin;
    logic [WIDTH:0]   addFull;
    logic [WIDTH-1:0] addSum, arithRes, logicRes, shNext;
    logic             addCout, addOvf, shOut;
    logic [SHW-1:0]   shAmt;

    // Every arithmetic op is folded onto one adder: subtraction is a + ~b + cin.
    always_comb begin
        isArith = 1'b1;
        addX    = a_q;
        addY    = b_q;
        addCin  = 1'b0;
        case (op_q)
            OP_ADD:  ;
            OP_ADDI: addCin = 1'b1;
            OP_INC:  begin addY = '0; addCin = 1'b1; end
            OP_SUBD: addY = ~b_q;
            OP_SUB:  begin addY = ~b_q; addCin = 1'b1; end
            OP_DEC:  addY = '1;
            default: isArith = 1'b0;
        endcase
    end

    assign addFull = {1'b0, addX} + {1'b0, addY} + {{WIDTH{1'b0}}, addCin};
    assign addSum  = addFull[WIDTH-1:0];
    assign addCout = addFull[WIDTH];
    assign addOvf  = (addX[WIDTH-1] == addY[WIDTH-1]) && (addSum[WIDTH-1] != addX[WIDTH-1]);

`ifdef ULA_SAT_EN
    assign arithRes = addOvf ? {addX[WIDTH-1], {(WIDTH-1){~addX[WIDTH-1]}}} : addSum;
`else
    assign arithRes = addSum;
`endif

    always_comb begin
        isLogic  = 1'b1;
        logicRes = '0;
        case (op_q)
            OP_AND:  logicRes = a_q & b_q;
            OP_OR:   logicRes = a_q | b_q;
            OP_XOR:  logicRes = a_q ^ b_q;
            OP_NOT:  logicRes = ~a_q;
            default: isLogic = 1'b0;
        endcase
    end

    // The shifter works in place on result_q; counts beyond WIDTH saturate at WIDTH steps.
    assign isShift = (op_q == OP_LSL) || (op_q == OP_LSR) || (op_q == OP_ASR);
    assign shAmt   = (b_q[SHW-1:0] > SH_MAX) ? SH_MAX : b_q[SHW-1:0];

    always_comb begin
        shNext = result_q;
        shOut  = 1'b0;
        case (op_q)
            OP_LSL:  begin shNext = {result_q[WIDTH-2:0], 1'b0};          shOut = result_q[WIDTH-1]; end
            OP_LSR:  begin shNext = {1'b0, result_q[WIDTH-1:1]};          shOut = result_q[0]; end
            OP_ASR:  begin shNext = {result_q[WIDTH-1], result_q[WIDTH-1:1]}; shOut = result_q[0]; end
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        z_d      = z_q;
        c_d      = c_q;
        s_d      = s_q;
        o_d      = o_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    op_d    = op;
                    a_d     = a;
                    b_d     = b;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                err_d   = 1'b0;
                c_d     = 1'b0;
                o_d     = 1'b0;
                state_d = S_DONE;
                if (isArith) begin
                    result_d = arithRes;
                    c_d      = addCout;
                    o_d      = addOvf;
                end else if (isLogic) begin
                    result_d = logicRes;
                end else if (isShift) begin
                    result_d = a_q;
                    cnt_d    = shAmt;
                    if (shAmt != '0) state_d = S_SHIFT;
                end else begin
                    result_d = '0;
                    err_d    = 1'b1;
                end
                z_d = (result_d == '0);
                s_d = result_d[WIDTH-1];
            end
            S_SHIFT: begin
                result_d = shNext;
                c_d      = shOut;
                z_d      = (shNext == '0);
                s_d      = shNext[WIDTH-1];
                cnt_d    = cnt_q - SH_ONE;
                if (cnt_q == SH_ONE) state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            z_q      <= 1'b0;
            c_q      <= 1'b0;
            s_q      <= 1'b0;
            o_q      <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            z_q      <= z_d;
            c_q      <= c_d;
            s_q      <= s_d;
            o_q      <= o_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    assign in_ready  = rst_n && (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign flag_z    = z_q;
    assign flag_c    = c_q;
    assign flag_s    = s_q;
    assign flag_o    = o_q;
    assign out_err   = err_q;

endmodule

// File: tb/tb_ula_seq.sv
// tb_ula_seq: directed checks of ula_seq at WIDTH=3 (legacy arithmetic) and WIDTH=8 (shifter timing).
// Latency is counted in clock edges after the accept edge until out_valid is first seen high.
module tb_ula_seq;

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_ADDI = 5'b00001;
    localparam logic [4:0] OP_INC  = 5'b00011;
    localparam logic [4:0] OP_SUBD = 5'b00100;
    localparam logic [4:0] OP_SUB  = 5'b00101;
    localparam logic [4:0] OP_DEC  = 5'b00110;
    localparam logic [4:0] OP_LSL  = 5'b01000;
    localparam logic [4:0] OP_LSR  = 5'b01001;
    localparam logic [4:0] OP_ASR  = 5'b01010;
    localparam logic [4:0] OP_AND  = 5'b10000;
    localparam logic [4:0] OP_OR   = 5'b10001;
    localparam logic [4:0] OP_XOR  = 5'b10010;
    localparam logic [4:0] OP_NOT  = 5'b10011;

    // Flags are packed {Z,C,S,O}; the *Sat fields apply when ULA_SAT_EN is defined.
    typedef struct packed {
        logic [4:0] op;
        logic [2:0] a;
        logic [2:0] b;
        logic [2:0] res;
        logic [3:0] flg;
        logic [2:0] resSat;
        logic [3:0] flgSat;
        logic       err;
        logic [3:0] lat;
    } vec3_t;

    typedef struct packed {
        logic [4:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic [3:0] flg;
        logic [7:0] resSat;
        logic [3:0] flgSat;
        logic [3:0] lat;
    } vec8_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       inValid3 = 1'b0, inReady3, outValid3, outReady3 = 1'b0;
    logic [4:0] op3 = '0;
    logic [2:0] a3 = '0, b3 = '0, result3;
    logic       z3, c3, s3, o3, err3;

    logic       inValid8 = 1'b0, inReady8, outValid8, outReady8 = 1'b0;
    logic [4:0] op8 = '0;
    logic [7:0] a8 = '0, b8 = '0, result8;
    logic       z8, c8, s8, o8, err8;

    int nChecks = 0;
    int nFails  = 0;

    ula_seq #(.WIDTH(3)) u3 (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid3), .in_ready(inReady3), .op(op3),
        .a(a3), .b(b3), .out_valid(outValid3), .out_ready(outReady3), .result(result3),
        .flag_z(z3), .flag_c(c3), .flag_s(s3), .flag_o(o3), .out_err(err3)
    );

    ula_seq #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid8), .in_ready(inReady8), .op(op8),
        .a(a8), .b(b8), .out_valid(outValid8), .out_ready(outReady8), .result(result8),
        .flag_z(z8), .flag_c(c8), .flag_s(s8), .flag_o(o8), .out_err(err8)
    );

    // Stimulus helpers only; every comparison lives in the test_* tasks.
    task automatic issue3(input logic [4:0] o, input logic [2:0] x, input logic [2:0] y);
        op3 = o; a3 = x; b3 = y; inValid3 = 1'b1;
        @(posedge clk); #1;
        inValid3 = 1'b0;
    endtask

    task automatic issue8(input logic [4:0] o, input logic [7:0] x, input logic [7:0] y);
        op8 = o; a8 = x; b8 = y; inValid8 = 1'b1;
        @(posedge clk); #1;
        inValid8 = 1'b0;
    endtask

    task automatic waitValid3(output int lat);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (outValid3) begin lat = i; break; end
        end
    endtask

    task automatic waitValid8(output int lat);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (outValid8) begin lat = i; break; end
        end
    endtask

    task automatic release3;
        outReady3 = 1'b1; @(posedge clk); #1; outReady3 = 1'b0;
    endtask

    task automatic release8;
        outReady8 = 1'b1; @(posedge clk); #1; outReady8 = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        nChecks++;
        if ({inReady3, outValid3, result3, z3, c3, s3, o3, err3} !== 10'b0) begin
            nFails++;
            $display("[TB] FAIL reset_w3: got %b expected 0", {inReady3, outValid3, result3, z3, c3, s3, o3, err3});
        end
        nChecks++;
        if ({inReady8, outValid8, result8, z8, c8, s8, o8, err8} !== 15'b0) begin
            nFails++;
            $display("[TB] FAIL reset_w8: got %b expected 0", {inReady8, outValid8, result8, z8, c8, s8, o8, err8});
        end
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        nChecks++;
        if ({inReady3, inReady8, outValid3, outValid8} !== 4'b1100) begin
            nFails++;
            $display("[TB] FAIL reset_release: got %b expected 1100", {inReady3, inReady8, outValid3, outValid8});
        end
    endtask

    task automatic test_ops_w3;
        vec3_t v [18];
        int    lat;
        logic [7:0] expOut;
        v = '{
            '{OP_ADD,  3'b001, 3'b111, 3'b000, 4'b1100, 3'b000, 4'b1100, 1'b0, 4'd1},
            '{OP_ADD,  3'b010, 3'b011, 3'b101, 4'b0011, 3'b011, 4'b0001, 1'b0, 4'd1},
            '{OP_SUBD, 3'b011, 3'b001, 3'b001, 4'b0100, 3'b001, 4'b0100, 1'b0, 4'd1},
            '{OP_ADD,  3'b100, 3'b111, 3'b011, 4'b0101, 3'b100, 4'b0111, 1'b0, 4'd1},
            '{OP_ADDI, 3'b001, 3'b001, 3'b011, 4'b0000, 3'b011, 4'b0000, 1'b0, 4'd1},
            '{OP_INC,  3'b011, 3'b000, 3'b100, 4'b0011, 3'b011, 4'b0001, 1'b0, 4'd1},
            '{OP_DEC,  3'b000, 3'b000, 3'b111, 4'b0010, 3'b111, 4'b0010, 1'b0, 4'd1},
            '{OP_SUB,  3'b000, 3'b100, 3'b100, 4'b0011, 3'b011, 4'b0001, 1'b0, 4'd1},
            '{OP_SUB,  3'b110, 3'b010, 3'b100, 4'b0110, 3'b100, 4'b0110, 1'b0, 4'd1},
            '{OP_AND,  3'b101, 3'b011, 3'b001, 4'b0000, 3'b001, 4'b0000, 1'b0, 4'd1},
            '{OP_OR,   3'b100, 3'b001, 3'b101, 4'b0010, 3'b101, 4'b0010, 1'b0, 4'd1},
            '{OP_XOR,  3'b101, 3'b101, 3'b000, 4'b1000, 3'b000, 4'b1000, 1'b0, 4'd1},
            '{OP_NOT,  3'b010, 3'b111, 3'b101, 4'b0010, 3'b101, 4'b0010, 1'b0, 4'd1},
            '{5'b00010, 3'b011, 3'b001, 3'b000, 4'b1000, 3'b000, 4'b1000, 1'b1, 4'd1},
            '{5'b11111, 3'b111, 3'b111, 3'b000, 4'b1000, 3'b000, 4'b1000, 1'b1, 4'd1},
            '{OP_LSR,  3'b110, 3'b001, 3'b011, 4'b0000, 3'b011, 4'b0000, 1'b0, 4'd2},
            '{OP_ASR,  3'b100, 3'b111, 3'b111, 4'b0110, 3'b111, 4'b0110, 1'b0, 4'd4},
            '{OP_LSL,  3'b011, 3'b010, 3'b100, 4'b0110, 3'b100, 4'b0110, 1'b0, 4'd3}
        };
        foreach (v[i]) begin
`ifdef ULA_SAT_EN
            expOut = {v[i].resSat, v[i].flgSat, v[i].err};
`else
            expOut = {v[i].res, v[i].flg, v[i].err};
`endif
            issue3(v[i].op, v[i].a, v[i].b);
            waitValid3(lat);
            nChecks++;
            if (lat != int'(v[i].lat)) begin
                nFails++;
                $display("[TB] FAIL w3_latency[%0d] op=%b: got %0d expected %0d", i, v[i].op, lat, v[i].lat);
            end
            nChecks++;
            if ({result3, z3, c3, s3, o3, err3} !== expOut) begin
                nFails++;
                $display("[TB] FAIL w3_result[%0d] op=%b a=%b b=%b: got res/ZCSO/err %b expected %b",
                         i, v[i].op, v[i].a, v[i].b, {result3, z3, c3, s3, o3, err3}, expOut);
            end
            release3();
        end
    endtask

    task automatic test_ops_w8;
        vec8_t v [6];
        int    lat;
        logic [11:0] expOut;
        v = '{
            '{OP_LSL, 8'h81, 8'h03, 8'h08, 4'b0000, 8'h08, 4'b0000, 4'd4},
            '{OP_ASR, 8'h80, 8'h0C, 8'hFF, 4'b0110, 8'hFF, 4'b0110, 4'd9},
            '{OP_LSR, 8'h01, 8'h00, 8'h01, 4'b0000, 8'h01, 4'b0000, 4'd1},
            '{OP_LSR, 8'h03, 8'h01, 8'h01, 4'b0100, 8'h01, 4'b0100, 4'd2},
            '{OP_ADD, 8'h7F, 8'h01, 8'h80, 4'b0011, 8'h7F, 4'b0001, 4'd1},
            '{OP_SUB, 8'h80, 8'h01, 8'h7F, 4'b0101, 8'h80, 4'b0111, 4'd1}
        };
        foreach (v[i]) begin
`ifdef ULA_SAT_EN
            expOut = {v[i].resSat, v[i].flgSat};
`else
            expOut = {v[i].res, v[i].flg};
`endif
            issue8(v[i].op, v[i].a, v[i].b);
            waitValid8(lat);
            nChecks++;
            if (lat != int'(v[i].lat)) begin
                nFails++;
                $display("[TB] FAIL w8_latency[%0d] op=%b: got %0d expected %0d", i, v[i].op, lat, v[i].lat);
            end
            nChecks++;
            if ({result8, z8, c8, s8, o8, err8} !== {expOut, 1'b0}) begin
                nFails++;
                $display("[TB] FAIL w8_result[%0d] op=%b a=%h b=%h: got res/ZCSO/err %b expected %b",
                         i, v[i].op, v[i].a, v[i].b, {result8, z8, c8, s8, o8, err8}, {expOut, 1'b0});
            end
            release8();
        end
    endtask

    // out_ready held high during CALC/SHIFT must not cut the shift short.
    task automatic test_early_ready;
        int lat;
        issue8(OP_LSL, 8'h0F, 8'h05);
        outReady8 = 1'b1;
        waitValid8(lat);
        nChecks++;
        if (lat != 6) begin
            nFails++;
            $display("[TB] FAIL early_ready_latency: got %0d expected 6", lat);
        end
        nChecks++;
        if ({result8, z8, c8, s8, o8} !== {8'hE0, 4'b0110}) begin
            nFails++;
            $display("[TB] FAIL early_ready_result: got %b expected %b", {result8, z8, c8, s8, o8}, {8'hE0, 4'b0110});
        end
        @(posedge clk); #1;
        outReady8 = 1'b0;
        nChecks++;
        if ({inReady8, outValid8} !== 2'b10) begin
            nFails++;
            $display("[TB] FAIL early_ready_return: got %b expected 10", {inReady8, outValid8});
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        issue3(OP_ADD, 3'b001, 3'b111);
        waitValid3(lat);
        nChecks++;
        if (lat != 1) begin
            nFails++;
            $display("[TB] FAIL bp_latency: got %0d expected 1", lat);
        end
        op3 = OP_XOR; a3 = 3'b111; b3 = 3'b000; inValid3 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            nChecks++;
            if ({outValid3, inReady3, result3, z3, c3, s3, o3, err3} !== {2'b10, 3'b000, 4'b1100, 1'b0}) begin
                nFails++;
                $display("[TB] FAIL bp_hold[%0d]: got %b expected %b", i,
                         {outValid3, inReady3, result3, z3, c3, s3, o3, err3}, {2'b10, 3'b000, 4'b1100, 1'b0});
            end
            @(posedge clk); #1;
        end
        inValid3 = 1'b0;
        release3();
        nChecks++;
        if ({inReady3, outValid3} !== 2'b10) begin
            nFails++;
            $display("[TB] FAIL bp_not_queued: got %b expected 10", {inReady3, outValid3});
        end
        issue3(OP_ADD, 3'b001, 3'b001);
        waitValid3(lat);
        nChecks++;
        if ({lat == 1, result3, z3, c3, s3, o3, err3} !== {1'b1, 3'b010, 4'b0000, 1'b0}) begin
            nFails++;
            $display("[TB] FAIL bp_next_op: got %b expected %b", {lat == 1, result3, z3, c3, s3, o3, err3},
                     {1'b1, 3'b010, 4'b0000, 1'b0});
        end
        release3();
    endtask

    task automatic test_reset_mid_shift;
        logic sawValid;
        issue8(OP_LSL, 8'hFF, 8'h07);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        nChecks++;
        if ({inReady8, outValid8, result8, z8, c8, s8, o8, err8} !== 15'b0) begin
            nFails++;
            $display("[TB] FAIL midshift_reset_outputs: got %b expected 0",
                     {inReady8, outValid8, result8, z8, c8, s8, o8, err8});
        end
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        nChecks++;
        if (inReady8 !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL midshift_ready_after_release: got %b expected 1", inReady8);
        end
        sawValid = outValid8;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            sawValid = sawValid | outValid8;
        end
        nChecks++;
        if (sawValid !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL midshift_stale_valid: got %b expected 0", sawValid);
        end
    endtask

    initial begin
        test_reset();
        test_ops_w3();
        test_ops_w8();
        test_early_ready();
        test_back_to_back();
        test_reset_mid_shift();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
